vpp_bcd_measure: RTL and testbench
==================================

# vpp_bcd_measure

Measurement stage that sits directly upstream of the seven-segment display driver in the oscilloscope datapath. It tracks minimum and maximum ADC codes over a fixed window of accepted samples and scales the peak-to-peak span to hundredths of a volt. It converts that value to three BCD digits with a sequential shift-add-3 engine. The digits feed the display's integer, first-decimal and second-decimal inputs, shown as X.YZ volts.

## Interface
Parameters:
- ADC_W, 8: ADC sample width in bits.
- WINDOW, 50000: accepted samples per measurement window. Legal range is 16 to 2^24.
- VREF_CENTI, 330: ADC full-scale reference in centivolts. Legal range is 1 to 1023.

Ports:
- clk, input, 1: system clock. Everything is rising-edge.
- rst, input, 1: reset, **synchronous, active-high**.
- sample_in, input, ADC_W: unsigned ADC code.
- sample_valid, input, 1: sample_in is accepted on each edge where this is high.
- integer_data, output, 4: BCD units digit (volts).
- float1_data, output, 4: BCD tenths digit.
- float2_data, output, 4: BCD hundredths digit.
- result_valid, output, 1: one-cycle pulse when the digits update.
- over_range, output, 1: high when the latest result was clamped to 9.99.

## Operation
- **Reset values:**
  - all three digits = 0, result_valid = 0, over_range = 0;
  - window counter = 0, max tracker = 0, min tracker = all ones;
  - FSM = S_IDLE.
- **Trackers:** on each accepted sample, max = max(max, sample) and min = min(min, sample). The window counter increments on accepted samples only; cycles with sample_valid low change nothing.
- **Window close:**
  - Closes on the accepted sample where counter == WINDOW-1. That sample is included in the window.
  - On the same edge: snapshot vpp = max' - min' (the values including that sample), clear the counter, reload max = 0 and min = all ones.
  - The next accepted sample starts the new window.
- **FSM:** S_IDLE -> S_MUL -> S_CONV -> S_LOAD -> S_IDLE.
  - **S_IDLE:** waits for a window close.
  - **S_MUL:** centi = (vpp * VREF_CENTI) >> ADC_W, computed in a product of ADC_W+10 bits. If centi > 999, centi = 999 and an over flag is set.
  - **S_CONV:** 10 iterations of shift-add-3 on the 10-bit centi. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts the whole register left by 1.
  - **S_LOAD:** writes the digits and over_range, and pulses result_valid.
- A window close while the FSM is not in S_IDLE cannot occur within the legal WINDOW range, because conversion takes 12 cycles and WINDOW ≥ 16. If it does occur, the snapshot is dropped and the outputs are unaffected.
- Between updates the outputs hold their last values.
- **rst mid-operation:** aborts the conversion (no result_valid pulse), restores all reset values and starts a fresh window.

## Timing
- E0 is the edge that accepts the closing sample.
- E1: centi registered.
- E2 to E11: shift-add-3 iterations.
- E12: digits and over_range updated, result_valid = 1 for the cycle following E12.
- Latency from closing-sample acceptance to result_valid is 12 cycles, fixed and independent of sample_valid.
- Trackers keep accepting samples during conversion; the measurement has no dead time.
- A sample accepted on the same edge as rst is discarded.

## Structure
- **Shared package vpp_bcd_pkg:**
  - FSM state encoding (S_IDLE, S_MUL, S_CONV, S_LOAD);
  - BCD_DIGITS = 3, CENTI_W = 10, CENTI_MAX = 999, CONV_STEPS = 10.
- **Sub-module bcd_shift_add3:**
  - Ports: start, 10-bit binary in, busy, done, 12-bit BCD out.
  - Owns the iteration counter and the S_CONV datapath.
- **Top level:** trackers, window counter, scaler and S_LOAD output registers.

## Test plan
- **Reset:** hold rst for 3 cycles with random samples -> all digits 0, result_valid 0, over_range 0; the first window begins after rst falls.
- **Full swing:** WINDOW=16, samples alternating 0/255 with sample_valid constant high -> vpp 255, centi 328, digits 3/2/8, over_range 0; result_valid pulses exactly once, 12 cycles after the 16th sample.
- **Flat and ramp:**
  - 16 samples of 128 -> 0/0/0.
  - Next window, ramp 100..115 -> vpp 15, centi 19, digits 0/1/9.
  - Confirms that trackers reload between windows.
- **Gapped valid:** sample_valid high on every 3rd cycle, random codes with min 20 and max 200 -> vpp 180, centi 232, digits 2/3/2; the close occurs on the 16th valid beat only.
- **Clamp:** VREF_CENTI=1023, vpp 255 -> centi 1019 clamped to 9/9/9, over_range 1; the next window with vpp 0 gives 0/0/0 and over_range 0.
- **Reset mid-conversion:** assert rst at E5 -> no result_valid, outputs return to 0, and the next window converts normally.

Source files
------------

// File: rtl/vpp_bcd_pkg.sv
// ---------------------------------------------------------------------------
// vpp_bcd_pkg
// Shared constants for the peak-to-peak measurement stage: FSM state codes,
// BCD/centivolt widths and the single shift-add-3 (double dabble) step used
// by the conversion engine.
// ---------------------------------------------------------------------------
package vpp_bcd_pkg;

    localparam int BCD_DIGITS = 3;
    localparam int CENTI_W    = 10;
    localparam int CENTI_MAX  = 999;
    localparam int CONV_STEPS = 10;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int SR_W       = BCD_W + CENTI_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_CONV = 2'd2;
    localparam logic [1:0] S_LOAD = 2'd3;

    // One double-dabble iteration on {bcd, binary}: every BCD nibble >= 5
    // gets +3, then the whole register shifts left by one.
    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] r);
        logic [SR_W-1:0] t;
        t = r;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (t[CENTI_W + 4*i +: 4] >= 4'd5) begin
                t[CENTI_W + 4*i +: 4] = t[CENTI_W + 4*i +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bcd_shift_add3.sv
// ---------------------------------------------------------------------------
// bcd_shift_add3
// Sequential binary-to-BCD converter, one shift-add-3 iteration per clock.
//   clk, rst  : clock, synchronous active-high reset
//   start_i   : load bin_i; the first iteration happens on this same edge
//   bin_i     : 10-bit binary value (0..999)
//   busy_o    : conversion in progress
//   done_o    : the final iteration completes on the coming edge
//   bcd_o     : 3-digit BCD result, valid once busy_o has dropped
// ---------------------------------------------------------------------------
module bcd_shift_add3
    import vpp_bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [CENTI_W-1:0] bin_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [BCD_W-1:0]   bcd_o
);

    localparam int STEP_W = 4;

    logic [SR_W-1:0]   sr_q, sr_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              busy_q, busy_d;

    always_comb begin
        sr_d   = sr_q;
        step_d = step_q;
        busy_d = busy_q;
        if (start_i) begin
            sr_d   = dd_step({{BCD_W{1'b0}}, bin_i});
            step_d = STEP_W'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            sr_d = dd_step(sr_q);
            if (step_q == STEP_W'(CONV_STEPS - 1)) begin
                step_d = '0;
                busy_d = 1'b0;
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            step_q <= step_d;
            busy_q <= busy_d;
        end
    end

    // Asserted one cycle early so the caller can leave its wait state on the
    // same edge that lands the final iteration.
    assign done_o = busy_q && (step_q == STEP_W'(CONV_STEPS - 1));
    assign busy_o = busy_q;
    assign bcd_o  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/vpp_bcd_measure.sv
// ---------------------------------------------------------------------------
// vpp_bcd_measure
// Tracks min/max ADC codes over WINDOW accepted samples, scales the span to
// centivolts, converts to BCD and presents X.YZ volts to the display driver.
//   clk, rst      : clock, synchronous active-high reset
//   sample_in     : unsigned ADC code
//   sample_valid  : sample_in accepted on this edge
//   integer_data  : BCD volts digit
//   float1_data   : BCD tenths digit
//   float2_data   : BCD hundredths digit
//   result_valid  : one-cycle pulse when the digits update
//   over_range    : latest result was clamped to 9.99
// ---------------------------------------------------------------------------
module vpp_bcd_measure
    import vpp_bcd_pkg::*;
#(
    parameter int ADC_W      = 8,
    parameter int WINDOW     = 50000,
    parameter int VREF_CENTI = 330
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] sample_in,
    input  logic             sample_valid,
    output logic [3:0]       integer_data,
    output logic [3:0]       float1_data,
    output logic [3:0]       float2_data,
    output logic             result_valid,
    output logic             over_range
);

    localparam int CNT_W  = $clog2(WINDOW);
    localparam int PROD_W = ADC_W + CENTI_W;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADC_W-1:0]   max_q, max_d, min_q, min_d;
    logic [ADC_W-1:0]   max_new, min_new, vpp_q, vpp_d;
    logic [1:0]         state_q, state_d;
    logic [CENTI_W-1:0] centi_q, centi_d, centi_raw;
    logic [PROD_W-1:0]  prod;
    logic               over_q, over_d, start_q, start_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, conv_bcd;
    logic               over_range_q, over_range_d, rv_q, rv_d;
    logic               close, conv_busy, conv_done;

    // Trackers and window counter; the closing sample is folded into
    // max_new/min_new before the snapshot is taken.
    always_comb begin
        cnt_d   = cnt_q;
        max_d   = max_q;
        min_d   = min_q;
        close   = 1'b0;
        max_new = (sample_in > max_q) ? sample_in : max_q;
        min_new = (sample_in < min_q) ? sample_in : min_q;
        if (sample_valid) begin
            if (cnt_q == CNT_W'(WINDOW - 1)) begin
                close = 1'b1;
                cnt_d = '0;
                max_d = '0;
                min_d = '1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                max_d = max_new;
                min_d = min_new;
            end
        end
    end

    assign prod      = PROD_W'(vpp_q) * PROD_W'(VREF_CENTI);
    assign centi_raw = prod[PROD_W-1 -: CENTI_W];

    always_comb begin
        state_d      = state_q;
        vpp_d        = vpp_q;
        centi_d      = centi_q;
        over_d       = over_q;
        start_d      = 1'b0;
        bcd_d        = bcd_q;
        over_range_d = over_range_q;
        rv_d         = 1'b0;
        case (state_q)
            // A close outside S_IDLE is dropped by simply not snapshotting.
            S_IDLE: if (close) begin
                vpp_d   = max_new - min_new;
                state_d = S_MUL;
            end
            S_MUL: begin
                if (centi_raw > CENTI_W'(CENTI_MAX)) begin
                    centi_d = CENTI_W'(CENTI_MAX);
                    over_d  = 1'b1;
                end else begin
                    centi_d = centi_raw;
                    over_d  = 1'b0;
                end
                if (!conv_busy) begin
                    start_d = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: if (conv_done) state_d = S_LOAD;
            S_LOAD: begin
                bcd_d        = conv_bcd;
                over_range_d = over_q;
                rv_d         = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            max_q        <= '0;
            min_q        <= '1;
            vpp_q        <= '0;
            state_q      <= S_IDLE;
            centi_q      <= '0;
            over_q       <= 1'b0;
            start_q      <= 1'b0;
            bcd_q        <= '0;
            over_range_q <= 1'b0;
            rv_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            min_q        <= min_d;
            vpp_q        <= vpp_d;
            state_q      <= state_d;
            centi_q      <= centi_d;
            over_q       <= over_d;
            start_q      <= start_d;
            bcd_q        <= bcd_d;
            over_range_q <= over_range_d;
            rv_q         <= rv_d;
        end
    end

    bcd_shift_add3 u_conv (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_q),
        .bin_i   (centi_q),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    assign integer_data = bcd_q[11:8];
    assign float1_data  = bcd_q[7:4];
    assign float2_data  = bcd_q[3:0];
    assign result_valid = rv_q;
    assign over_range   = over_range_q;

endmodule

// File: tb/tb_vpp_bcd_measure.sv
// ---------------------------------------------------------------------------
// tb_vpp_bcd_measure
// Two instances (VREF 3.30 V and 10.23 V, WINDOW 16) share one stimulus.
// A window-level model predicts every output every cycle; captured results
// are also pinned against hand-computed digit tables.
// ---------------------------------------------------------------------------
module tb_vpp_bcd_measure;

    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b1;
    logic [7:0] sample_in = 8'd0;

    logic [3:0] int_a, f1_a, f2_a, int_b, f1_b, f2_b;
    logic       rv_a, ov_a, rv_b, ov_b;

    vpp_bcd_measure #(.ADC_W(8), .WINDOW(W), .VREF_CENTI(330)) dut_a (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .integer_data(int_a), .float1_data(f1_a), .float2_data(f2_a),
        .result_valid(rv_a), .over_range(ov_a)
    );

    vpp_bcd_measure #(.ADC_W(8), .WINDOW(W), .VREF_CENTI(1023)) dut_b (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .integer_data(int_b), .float1_data(f1_b), .float2_data(f2_b),
        .result_valid(rv_b), .over_range(ov_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt, m_max, m_min, m_due, m_vpp, m_cyc, v_snap, c;
    bit m_idle, armed;
    int exp_bcd[2], exp_ov[2], vref[2];
    int exp_rv;
    int cap_a[$], cap_b[$];

    function automatic int centi_of(input int vpp, input int vr);
        int x;
        x = (vpp * vr) / 256;
        return (x > 999) ? 999 : x;
    endfunction

    function automatic int to_bcd(input int x);
        return (x / 100) * 256 + ((x / 10) % 10) * 16 + (x % 10);
    endfunction

    initial begin
        vref    = '{330, 1023};
        m_cnt   = 0; m_max = 0; m_min = 255; m_due = -1; m_vpp = 0; m_cyc = 0;
        exp_bcd = '{0, 0}; exp_ov = '{0, 0}; exp_rv = 0; armed = 0;
        forever begin
            @(negedge clk);
            if (armed) begin
                check("a_digits", 32'({int_a, f1_a, f2_a}), exp_bcd[0]);
                check("a_over",   32'(ov_a), exp_ov[0]);
                check("a_valid",  32'(rv_a), exp_rv);
                check("b_digits", 32'({int_b, f1_b, f2_b}), exp_bcd[1]);
                check("b_over",   32'(ov_b), exp_ov[1]);
                check("b_valid",  32'(rv_b), exp_rv);
                if (rv_a === 1'b1) cap_a.push_back(int'(ov_a) * 4096 + int'({int_a, f1_a, f2_a}));
                if (rv_b === 1'b1) cap_b.push_back(int'(ov_b) * 4096 + int'({int_b, f1_b, f2_b}));
            end
            // advance the model to the coming rising edge using the inputs now applied
            m_cyc++;
            exp_rv = 0;
            if (rst) begin
                m_cnt = 0; m_max = 0; m_min = 255; m_due = -1;
                exp_bcd = '{0, 0}; exp_ov = '{0, 0};
                armed = 1;
            end else begin
                m_idle = (m_due < 0);
                if (m_due == m_cyc) begin
                    for (int k = 0; k < 2; k++) begin
                        c = centi_of(m_vpp, vref[k]);
                        exp_bcd[k] = to_bcd(c);
                        exp_ov[k]  = ((m_vpp * vref[k]) / 256 > 999) ? 1 : 0;
                    end
                    exp_rv = 1;
                    m_due  = -1;
                end
                if (sample_valid) begin
                    if (int'(sample_in) > m_max) m_max = int'(sample_in);
                    if (int'(sample_in) < m_min) m_min = int'(sample_in);
                    m_cnt++;
                    if (m_cnt == W) begin
                        v_snap = m_max - m_min;
                        m_cnt = 0; m_max = 0; m_min = 255;
                        if (m_idle) begin
                            m_vpp = v_snap;
                            m_due = m_cyc + 12;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic v, input logic [7:0] s);
        @(posedge clk);
        #1;
        rst = r;
        sample_valid = v;
        sample_in = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0);
    endtask

    task automatic swing();
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, (i % 2 == 1) ? 8'd255 : 8'd0);
    endtask

    task automatic ramp();
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, 8'(100 + i));
    endtask

    int exp_a[5], exp_b[5];
    logic [7:0] code;

    initial begin
        exp_a = '{'h0328, 'h0000, 'h0019, 'h0232, 'h0019};
        exp_b = '{'h1999, 'h0000, 'h0059, 'h0719, 'h0059};
        sample_in = 8'($urandom);

        // reset held for three edges with random samples
        step(1'b1, 1'b1, 8'($urandom));
        step(1'b1, 1'b1, 8'($urandom));
        step(1'b0, 1'b1, 8'd0);
        check("rst_digits", 32'({int_a, f1_a, f2_a, int_b, f1_b, f2_b}), 32'd0);
        check("rst_valid",  32'({rv_a, rv_b}), 32'd0);
        check("rst_over",   32'({ov_a, ov_b}), 32'd0);

        // full swing (first sample already applied), then flat right away
        for (int i = 1; i < W; i++) step(1'b0, 1'b1, (i % 2 == 1) ? 8'd255 : 8'd0);
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, 8'd128);
        idle(14);

        ramp();
        idle(14);

        // gapped valid: one valid beat in three, idle beats carry extremes
        for (int b = 0; b < W; b++) begin
            if (b == 3)      code = 8'd20;
            else if (b == 9) code = 8'd200;
            else             code = 8'($urandom_range(21, 199));
            step(1'b0, 1'b1, code);
            step(1'b0, 1'b0, 8'd255);
            step(1'b0, 1'b0, 8'd0);
        end
        idle(14);

        // reset landing on E5 of a conversion
        swing();
        idle(4);
        step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        check("midrst_digits", 32'({int_a, f1_a, f2_a, int_b, f1_b, f2_b}), 32'd0);
        check("midrst_over",   32'({ov_a, ov_b}), 32'd0);
        idle(15);
        ramp();
        idle(14);
        idle(2);

        check("a_result_count", 32'(cap_a.size()), 32'd5);
        check("b_result_count", 32'(cap_b.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < cap_a.size()) check("a_result_lit", 32'(cap_a[i]), 32'(exp_a[i]));
            if (i < cap_b.size()) check("b_result_lit", 32'(cap_b[i]), 32'(exp_b[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
